// File: rtl/frame_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_scan_pkg
// Description : Shared types and constants for the frame scan serializer and
//               the frame register file bench.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_scan_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } scan_state_t;

    localparam int c_WORDS_DEF        = 16;
    localparam int c_WIDTH_DEF        = 32;
    localparam int c_HALF_PERIOD_DEF  = 2;
    localparam int c_LATCH_CYCLES_DEF = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_clock_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bit_clock_gen
// Description : Phase counter generating the serial bit clock level and an
//               end-of-bit strobe. Runs only while shifting, restarts on entry.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_clock_gen
    import frame_scan_pkg::*;
#(
    parameter int HALF_PERIOD = c_HALF_PERIOD_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,      // next cycle is a shift cycle
    input  logic i_clr,      // current cycle is not a shift cycle (entry)
    output logic o_sclk,
    output logic o_bit_end
);

    localparam int                c_PH_W    = cnt_w(2 * HALF_PERIOD);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [c_PH_W-1:0] c_PH_HIGH = c_PH_W'(HALF_PERIOD);

    logic [c_PH_W-1:0] r_phase;
    logic [c_PH_W-1:0] w_phase_nxt;
    logic              r_sclk;

    // Phase of the upcoming cycle: zero on entry or outside shift, else wraps per bit
    always_comb begin
        w_phase_nxt = '0;
        if (i_run && !i_clr) begin
            w_phase_nxt = (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
        end
    end

    // Phase register and registered sclk level (low half then high half)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_sclk  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_sclk  <= i_run && (w_phase_nxt >= c_PH_HIGH);
        end
    end

    assign o_sclk    = r_sclk;
    assign o_bit_end = (r_phase == c_PH_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_scan_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_scan_serializer
// Description : Snapshots all frame words on request and shifts them out MSB
//               first on a serial display link with bit clock and word latch.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scan_serializer
    import frame_scan_pkg::*;
#(
    parameter int WORDS        = c_WORDS_DEF,
    parameter int WIDTH        = c_WIDTH_DEF,
    parameter int HALF_PERIOD  = c_HALF_PERIOD_DEF,
    parameter int LATCH_CYCLES = c_LATCH_CYCLES_DEF
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WORDS*WIDTH-1:0]   frames_flat,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     sdata,
    output logic                     sclk,
    output logic                     latch,
    output logic [$clog2(WORDS)-1:0] row_idx
);

    localparam int                 c_ROW_W    = $clog2(WORDS);
    localparam int                 c_BIT_W    = cnt_w(WIDTH);
    localparam int                 c_LAT_W    = cnt_w(LATCH_CYCLES + 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(WORDS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_TOP  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(LATCH_CYCLES - 1);

    scan_state_t        r_state, w_state_nxt;
    logic [c_ROW_W-1:0] r_row, w_row_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic [c_LAT_W-1:0] r_lat, w_lat_nxt;
    logic               r_pending, w_pending_nxt;
    logic               w_scan_end;
    logic               w_bit_end;
    logic               w_clk_run, w_clk_clr;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   w_frame  [WORDS];
    logic [WIDTH-1:0]   r_shadow [WORDS];
    logic               r_busy, r_done, r_sdata, r_latch;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_frame
            assign w_frame[gi] = frames_flat[WIDTH*gi +: WIDTH];
        end
    endgenerate

    assign w_clk_run = (w_state_nxt == SHIFT);
    assign w_clk_clr = (r_state != SHIFT);

    bit_clock_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_bit_clock_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (i_clr_guard(w_clk_run)),
        .i_clr     (w_clk_clr),
        .o_sclk    (sclk),
        .o_bit_end (w_bit_end)
    );

    // Identity pass-through keeps the run enable a plain wire expression
    function automatic logic i_clr_guard(input logic v);
        return v;
    endfunction

    // Next-state, counters and pending request; the word feeding sdata next cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_bit_nxt     = r_bit;
        w_lat_nxt     = '0;
        w_pending_nxt = r_pending;
        w_scan_end    = 1'b0;
        // A request while a scan is in flight is remembered (depth one)
        if (start && (r_state != IDLE)) begin
            w_pending_nxt = 1'b1;
        end
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_row_nxt   = '0;
                end
            end
            LOAD: begin
                w_state_nxt = SHIFT;
                w_row_nxt   = '0;
                w_bit_nxt   = c_BIT_TOP;
            end
            SHIFT: begin
                if (w_bit_end) begin
                    if (r_bit == '0) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_bit_nxt = r_bit - c_BIT_W'(1);
                    end
                end
            end
            LATCH: begin
                if (r_lat == c_LAT_LAST) begin
                    if (r_row == c_ROW_LAST) begin
                        w_scan_end = 1'b1;
                        w_row_nxt  = '0;
                        // A request arriving in this very cycle also triggers the rescan
                        if (r_pending || start) begin
                            w_state_nxt   = LOAD;
                            w_pending_nxt = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = SHIFT;
                        w_row_nxt   = r_row + c_ROW_W'(1);
                        w_bit_nxt   = c_BIT_TOP;
                    end
                end else begin
                    w_lat_nxt = r_lat + c_LAT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // During LOAD the shadow is not yet written, so the first bit comes straight from the input
        w_word = (r_state == LOAD) ? w_frame[0] : r_shadow[w_row_nxt];
    end

    // Sequencer registers and registered outputs, all computed from next-cycle values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_bit     <= '0;
            r_lat     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sdata   <= 1'b0;
            r_latch   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_bit     <= w_bit_nxt;
            r_lat     <= w_lat_nxt;
            r_pending <= w_pending_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_scan_end;
            r_sdata   <= (w_state_nxt == SHIFT) ? w_word[w_bit_nxt] : 1'b0;
            r_latch   <= (w_state_nxt == LATCH);
        end
    end

    // Shadow buffer captured once per scan so upstream writes cannot tear the display
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == LOAD)) begin
            for (int i = 0; i < WORDS; i++) begin
                r_shadow[i] <= w_frame[i];
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sdata   = r_sdata;
    assign latch   = r_latch;
    assign row_idx = r_row;

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_scan_serializer
// Description : Self-checking bench for frame_scan_serializer: default build
//               plus a small build (4 words, 1-cycle half period and latch).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scan_serializer;

    localparam int WIDTH   = 32;
    localparam int WORDS   = 16;
    localparam int S_WORDS = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     start_s;
    logic [WORDS*WIDTH-1:0]   frames_flat;
    logic [S_WORDS*WIDTH-1:0] frames_s;

    logic       busy, done, sdata, sclk, latch;
    logic [3:0] row_idx;
    logic       busy_s, done_s, sdata_s, sclk_s, latch_s;
    logic [1:0] row_s;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    frame_scan_serializer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frames_flat (frames_flat),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sdata       (sdata),
        .sclk        (sclk),
        .latch       (latch),
        .row_idx     (row_idx)
    );

    frame_scan_serializer #(
        .WORDS        (4),
        .WIDTH        (32),
        .HALF_PERIOD  (1),
        .LATCH_CYCLES (1)
    ) u_dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .frames_flat (frames_s),
        .start       (start_s),
        .busy        (busy_s),
        .done        (done_s),
        .sdata       (sdata_s),
        .sclk        (sclk_s),
        .latch       (latch_s),
        .row_idx     (row_s)
    );

    // Expected {busy,done,sdata,sclk,latch,row[3:0]} in cycle t after start sampled in cycle 0
    function automatic logic [8:0] model(input logic [31:0] s [16], input int words,
                                         input int hp, input int lc, input int t);
        int         p, u, k, r, b;
        logic [3:0] row;
        p = WIDTH * 2 * hp + lc;
        if (t <= 0) return 9'd0;
        if (t == 1) return 9'h100;
        u = t - 2;
        k = u / p;
        r = u % p;
        if (k >= words) return (k == words && r == 0) ? 9'h080 : 9'd0;
        row = 4'(k);
        if (r < WIDTH * 2 * hp) begin
            b = WIDTH - 1 - r / (2 * hp);
            return {1'b1, 1'b0, s[k][b], ((r % (2 * hp)) >= hp), 1'b0, row};
        end
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, row};
    endfunction

    task automatic load_frames(input logic [31:0] w [16]);
        for (int i = 0; i < WORDS; i++) frames_flat[WIDTH*i +: WIDTH] = w[i];
    endtask

    task automatic test_reset();
        int sclk_rises = 0;
        logic prev = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b1;
        start_s = 1'b1;
        frames_flat = '1;
        frames_s    = '1;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, sdata, sclk, latch, row_idx} !== 9'd0)
                $display("FAIL reset_outputs cycle %0d: got %b expected 0", c,
                         {busy, done, sdata, sclk, latch, row_idx});
            else passed++;
            checks++;
            if ({busy_s, done_s, sdata_s, sclk_s, latch_s, row_s} !== 7'd0)
                $display("FAIL reset_outputs_small cycle %0d: got %b expected 0", c,
                         {busy_s, done_s, sdata_s, sclk_s, latch_s, row_s});
            else passed++;
            if (sclk && !prev) sclk_rises++;
            prev = sclk;
        end
        rst_n   = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sclk && !prev) sclk_rises++;
            prev = sclk;
        end
        checks++;
        if ({busy, busy_s} !== 2'b00)
            $display("FAIL reset_idle_after_release: busy %b expected 00", {busy, busy_s});
        else passed++;
        checks++;
        if (sclk_rises !== 0)
            $display("FAIL reset_no_sclk: rises %0d expected 0", sclk_rises);
        else passed++;
    endtask

    task automatic test_single_scan();
        logic [31:0] w [16];
        logic [8:0]  expv, obs;
        int          n_latch = 0, done_at = -1;
        logic        prev_latch = 1'b0;
        for (int i = 0; i < WORDS; i++) w[i] = 32'd0;
        w[0]  = 32'h8000_0001;
        w[15] = 32'hFFFF_FFFF;
        load_frames(w);
        for (int t = 0; t <= 2085; t++) begin
            @(negedge clk);
            start = (t == 0);
            obs  = {busy, done, sdata, sclk, latch, row_idx};
            expv = model(w, 16, 2, 2, t);
            checks++;
            if (obs !== expv)
                $display("FAIL single_scan cycle %0d: got %b expected %b", t, obs, expv);
            else passed++;
            if (latch && !prev_latch) n_latch++;
            prev_latch = latch;
            if (done) done_at = t;
        end
        start = 1'b0;
        checks++;
        if (n_latch !== 16) $display("FAIL single_latch_count: got %0d expected 16", n_latch);
        else passed++;
        checks++;
        if (done_at !== 2082) $display("FAIL single_done_cycle: got %0d expected 2082", done_at);
        else passed++;
    endtask

    task automatic test_tear_free();
        logic [31:0] w [16];
        logic [31:0] cap [16];
        int          nb [16];
        logic [8:0]  expv, obs;
        logic        prev = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            w[i] = $urandom();
            cap[i] = 32'd0;
            nb[i] = 0;
        end
        load_frames(w);
        for (int t = 0; t <= 2085; t++) begin
            @(negedge clk);
            start = (t == 0);
            if (t == 2 + 130 * 3 + 10) frames_flat = {WORDS{32'hA5A5_A5A5}};
            obs  = {busy, done, sdata, sclk, latch, row_idx};
            expv = model(w, 16, 2, 2, t);
            checks++;
            if (obs !== expv)
                $display("FAIL tear_free cycle %0d: got %b expected %b", t, obs, expv);
            else passed++;
            if (sclk && !prev) begin
                cap[row_idx] = {cap[row_idx][30:0], sdata};
                nb[row_idx]++;
            end
            prev = sclk;
        end
        start = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (cap[i] !== w[i] || nb[i] != 32)
                $display("FAIL tear_free_word %0d: got %h (%0d bits) expected %h (32 bits)",
                         i, cap[i], nb[i], w[i]);
            else passed++;
        end
    endtask

    task automatic test_pending();
        logic [31:0] wa [16];
        logic [31:0] wb [16];
        logic [31:0] ca [16];
        logic [31:0] cb [16];
        int          dones = 0, first_done = -1;
        logic        gap = 1'b0, prev = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            wa[i] = $urandom();
            wb[i] = $urandom();
            ca[i] = 32'd0;
            cb[i] = 32'd0;
        end
        load_frames(wa);
        for (int t = 0; t <= 5000; t++) begin
            @(negedge clk);
            start = (t == 0) || (t == 500) || (t == 600);
            if (t == 2000) load_frames(wb);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = t;
            end
            if (t >= 1 && dones < 2 && !busy) gap = 1'b1;
            if (sclk && !prev) begin
                if (dones == 0) ca[row_idx] = {ca[row_idx][30:0], sdata};
                else            cb[row_idx] = {cb[row_idx][30:0], sdata};
            end
            prev = sclk;
        end
        start = 1'b0;
        checks++;
        if (dones !== 2) $display("FAIL pending_done_count: got %0d expected 2", dones);
        else passed++;
        checks++;
        if (first_done !== 2082) $display("FAIL pending_first_done: got %0d expected 2082", first_done);
        else passed++;
        checks++;
        if (gap !== 1'b0) $display("FAIL pending_busy_gap: got %b expected 0", gap);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL pending_final_idle: busy %b expected 0", busy);
        else passed++;
        for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (ca[i] !== wa[i] || cb[i] !== wb[i])
                $display("FAIL pending_stream word %0d: got %h/%h expected %h/%h",
                         i, ca[i], cb[i], wa[i], wb[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] w [16];
        logic [8:0]  expv, obs;
        int          stray = 0;
        for (int i = 0; i < WORDS; i++) w[i] = $urandom();
        load_frames(w);
        for (int t = 0; t <= 701; t++) begin
            @(negedge clk);
            start = (t == 0) || (t == 650);
            rst_n = (t != 700);
            obs = {busy, done, sdata, sclk, latch, row_idx};
            if (t <= 700) begin
                expv = model(w, 16, 2, 2, t);
                checks++;
                if (obs !== expv)
                    $display("FAIL midreset_prefix cycle %0d: got %b expected %b", t, obs, expv);
                else passed++;
            end else begin
                checks++;
                if (obs !== 9'd0) $display("FAIL midreset_outputs: got %b expected 0", obs);
                else passed++;
            end
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int t = 0; t < 2200; t++) begin
            @(negedge clk);
            if (busy || done) stray++;
        end
        checks++;
        if (stray !== 0) $display("FAIL midreset_pending_cleared: active cycles %0d expected 0", stray);
        else passed++;
        for (int i = 0; i < WORDS; i++) w[i] = $urandom();
        load_frames(w);
        for (int t = 0; t <= 2085; t++) begin
            @(negedge clk);
            start = (t == 0);
            obs  = {busy, done, sdata, sclk, latch, row_idx};
            expv = model(w, 16, 2, 2, t);
            checks++;
            if (obs !== expv)
                $display("FAIL midreset_rescan cycle %0d: got %b expected %b", t, obs, expv);
            else passed++;
        end
        start = 1'b0;
    endtask

    task automatic test_params_small();
        logic [31:0] w [16];
        logic [8:0]  expv, obs;
        int          done_at = -1;
        for (int i = 0; i < WORDS; i++) w[i] = (i < S_WORDS) ? $urandom() : 32'd0;
        for (int i = 0; i < S_WORDS; i++) frames_s[WIDTH*i +: WIDTH] = w[i];
        for (int t = 0; t <= 265; t++) begin
            @(negedge clk);
            start_s = (t == 0);
            obs  = {busy_s, done_s, sdata_s, sclk_s, latch_s, 2'b00, row_s};
            expv = model(w, 4, 1, 1, t);
            checks++;
            if (obs !== expv)
                $display("FAIL small_params cycle %0d: got %b expected %b", t, obs, expv);
            else passed++;
            if (done_s) done_at = t;
        end
        start_s = 1'b0;
        checks++;
        if (done_at !== 262) $display("FAIL small_done_cycle: got %0d expected 262", done_at);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_tear_free();
        test_pending();
        test_reset_mid_scan();
        test_params_small();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
